// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
//   - FSM state encodings (IDLE / IF_ACC / D_ACC)
//   - requester identifiers
//   - width of the access latency counter and its load-value helper
package imem_dmem_arbiter_pkg;

  // Latency counter width: holds MEM_LATENCY-1 for MEM_LATENCY up to 15.
  localparam int CNT_W = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_IF_ACC = 2'd1;
  localparam logic [1:0] ST_D_ACC  = 2'd2;

  typedef enum logic [0:0] {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } req_id_e;

  // Counter value loaded on grant so that the final cycle is reached after
  // exactly lat cycles including the grant cycle.
  function automatic logic [CNT_W-1:0] cnt_load_value(input int lat);
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/imem_dmem_arbiter_latency_counter.sv
// Access latency counter for the memory arbiter.
//   clk, reset  : clock, synchronous active-high reset
//   load        : load load_value (takes precedence over dec)
//   load_value  : value loaded on grant
//   dec         : decrement request; saturates at zero, never wraps
//   zero        : count is zero (final cycle of an access)
//   one         : count is one (cycle before the final cycle)
module imem_dmem_arbiter_latency_counter
  import imem_dmem_arbiter_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic         zero,
  output logic         one
);

  localparam logic [W-1:0] ZERO_C = {W{1'b0}};
  localparam logic [W-1:0] ONE_C  = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] count_r;

  // Count register: load on grant, otherwise count down to zero and hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= ZERO_C;
    end else if (load) begin
      count_r <= load_value;
    end else if (dec && (count_r != ZERO_C)) begin
      count_r <= count_r - ONE_C;
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == ZERO_C);
  assign one  = (count_r == ONE_C);

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Arbiter sharing one single-ported LC-3b memory between instruction fetch
// and the MEM stage. Each access takes MEM_LATENCY cycles from grant to a
// one-cycle ready pulse. Data requests win over fetch on a tie.
//
// Optional feature macro: IMEM_ARB_STARVE_GUARD_EN
//   defined   : after STARVE_LIMIT consecutive data grants while a fetch is
//               pending, the next grant goes to fetch.
//   undefined : strict data priority.
//
// Ports:
//   clk, reset              pipeline clock, synchronous active-high reset
//   if_req/if_addr          fetch request (level) and PC
//   imem_r/if_rdata         fetch ready pulse, instruction word (held)
//   d_req/d_addr            data request (level) and address
//   d_we_low/d_we_high      byte write enables, d_wdata write data
//   dmem_r/d_rdata          data ready pulse, read data (held)
//   ram_en/ram_addr         memory enable (whole access), latched address
//   ram_we_low/ram_we_high  byte strobes, final cycle of a write only
//   ram_wdata/ram_rdata     latched write data, memory read data
//   busy                    access in flight
module imem_dmem_arbiter
  import imem_dmem_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY  = 4,
  parameter int ADDR_W       = 16,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              imem_r,
  output logic [15:0]       if_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_we_low,
  input  logic              d_we_high,
  input  logic [15:0]       d_wdata,
  output logic              dmem_r,
  output logic [15:0]       d_rdata,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we_low,
  output logic              ram_we_high,
  output logic [15:0]       ram_wdata,
  input  logic [15:0]       ram_rdata,
  output logic              busy
);

  localparam logic [CNT_W-1:0] LOAD_VAL_C = cnt_load_value(MEM_LATENCY);
  localparam logic             LOAD_ZERO_C = (MEM_LATENCY == 1);

  if ((MEM_LATENCY < 1) || (MEM_LATENCY > 15)) begin : g_bad_latency
    $error("MEM_LATENCY must be within 1..15");
  end
  if (STARVE_LIMIT < 1) begin : g_bad_starve
    $error("STARVE_LIMIT must be at least 1");
  end

  logic [1:0] state_r;
  logic [1:0] next_state_s;
  logic       grant_if_s;
  logic       grant_d_s;
  logic       finish_if_s;
  logic       finish_d_s;
  logic       d_wins_s;
  logic       we_low_lat_r;
  logic       we_high_lat_r;
  logic       we_any_s;
  logic       d_drop_r;
  logic       strobe_low_s;
  logic       strobe_high_s;
  logic       cnt_zero_s;
  logic       cnt_one_s;
  req_id_e    grant_id_s;

  assign we_any_s = we_low_lat_r | we_high_lat_r;

`ifdef IMEM_ARB_STARVE_GUARD_EN
  localparam int SW = ($clog2(STARVE_LIMIT + 1) < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX_C = SW'(STARVE_LIMIT);
  localparam logic [SW-1:0] STARVE_ONE_C = {{(SW-1){1'b0}}, 1'b1};

  logic [SW-1:0] starve_cnt_r;
  logic          starve_hit_s;

  assign starve_hit_s = if_req && (starve_cnt_r >= STARVE_MAX_C);
  assign d_wins_s     = d_req && !starve_hit_s;

  // Consecutive data grants taken while a fetch was waiting.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_r <= {SW{1'b0}};
    end else if (grant_if_s) begin
      starve_cnt_r <= {SW{1'b0}};
    end else if (grant_d_s && if_req && (starve_cnt_r < STARVE_MAX_C)) begin
      starve_cnt_r <= starve_cnt_r + STARVE_ONE_C;
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end
`else
  assign d_wins_s = d_req;
`endif

  // Next-state, grant and completion decode.
  always_comb begin
    next_state_s = state_r;
    grant_if_s   = 1'b0;
    grant_d_s    = 1'b0;
    finish_if_s  = 1'b0;
    finish_d_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (d_wins_s) begin
          grant_d_s    = 1'b1;
          next_state_s = ST_D_ACC;
        end else if (if_req) begin
          grant_if_s   = 1'b1;
          next_state_s = ST_IF_ACC;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_IF_ACC: begin
        // Withdrawn fetch (branch redirect) ends the access without a pulse.
        if (!if_req) begin
          next_state_s = ST_IDLE;
        end else if (cnt_zero_s) begin
          finish_if_s  = 1'b1;
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_IF_ACC;
        end
      end
      ST_D_ACC: begin
        // A withdrawn read aborts; a write always runs to completion.
        if (!d_req && !we_any_s) begin
          next_state_s = ST_IDLE;
        end else if (cnt_zero_s) begin
          finish_d_s   = 1'b1;
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_D_ACC;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Requester selection for the address latch.
  always_comb begin
    if (grant_d_s) begin
      grant_id_s = REQ_D;
    end else begin
      grant_id_s = REQ_IF;
    end
  end

  // Byte strobes are registered, so they are computed one edge ahead of the
  // final (count==0) cycle: either on grant when the latency is one, or in
  // the count==1 cycle of a continuing data access.
  always_comb begin
    if (grant_d_s && LOAD_ZERO_C) begin
      strobe_low_s  = d_we_low;
      strobe_high_s = d_we_high;
    end else if ((state_r == ST_D_ACC) && cnt_one_s && (next_state_s == ST_D_ACC)) begin
      strobe_low_s  = we_low_lat_r;
      strobe_high_s = we_high_lat_r;
    end else begin
      strobe_low_s  = 1'b0;
      strobe_high_s = 1'b0;
    end
  end

  imem_dmem_arbiter_latency_counter #(
    .W(CNT_W)
  ) u_latency_counter (
    .clk       (clk),
    .reset     (reset),
    .load      (grant_if_s | grant_d_s),
    .load_value(LOAD_VAL_C),
    .dec       (state_r != ST_IDLE),
    .zero      (cnt_zero_s),
    .one       (cnt_one_s)
  );

  // FSM state, latched write enables and the data-withdrawn flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      we_low_lat_r  <= 1'b0;
      we_high_lat_r <= 1'b0;
      d_drop_r      <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (grant_d_s) begin
        we_low_lat_r  <= d_we_low;
        we_high_lat_r <= d_we_high;
      end else if (grant_if_s) begin
        we_low_lat_r  <= 1'b0;
        we_high_lat_r <= 1'b0;
      end else begin
        we_low_lat_r  <= we_low_lat_r;
        we_high_lat_r <= we_high_lat_r;
      end
      if (grant_if_s || grant_d_s) begin
        d_drop_r <= 1'b0;
      end else if ((state_r == ST_D_ACC) && !d_req) begin
        d_drop_r <= 1'b1;
      end else begin
        d_drop_r <= d_drop_r;
      end
    end
  end

  // Registered memory-side and pipeline-side outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      imem_r      <= 1'b0;
      dmem_r      <= 1'b0;
      if_rdata    <= 16'h0000;
      d_rdata     <= 16'h0000;
      ram_en      <= 1'b0;
      busy        <= 1'b0;
      ram_addr    <= {ADDR_W{1'b0}};
      ram_wdata   <= 16'h0000;
      ram_we_low  <= 1'b0;
      ram_we_high <= 1'b0;
    end else begin
      imem_r      <= finish_if_s;
      // A write whose requester walked away still strobes but is not acknowledged.
      dmem_r      <= finish_d_s && d_req && !d_drop_r;
      ram_en      <= (next_state_s != ST_IDLE);
      busy        <= (next_state_s != ST_IDLE);
      ram_we_low  <= strobe_low_s;
      ram_we_high <= strobe_high_s;
      if (finish_if_s) begin
        if_rdata <= ram_rdata;
      end else begin
        if_rdata <= if_rdata;
      end
      if (finish_d_s && !we_any_s) begin
        d_rdata <= ram_rdata;
      end else begin
        d_rdata <= d_rdata;
      end
      if (grant_if_s || grant_d_s) begin
        ram_addr <= (grant_id_s == REQ_D) ? d_addr : if_addr;
      end else begin
        ram_addr <= ram_addr;
      end
      if (grant_d_s) begin
        ram_wdata <= d_wdata;
      end else begin
        ram_wdata <= ram_wdata;
      end
    end
  end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Self-checking bench for imem_dmem_arbiter. A behavioural memory answers the
// arbiter; a separate reference memory tracks the expected contents from the
// writes the bench issues. Timing expectations follow the arbiter rules:
// grant to ready = L cycles, data wins ties, ready cycle is the only bubble.
module tb_imem_dmem_arbiter;

  localparam int L  = 4;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          imem_r;
  logic [15:0]   if_rdata;
  logic          d_req;
  logic [AW-1:0] d_addr;
  logic          d_we_low;
  logic          d_we_high;
  logic [15:0]   d_wdata;
  logic          dmem_r;
  logic [15:0]   d_rdata;
  logic          ram_en;
  logic [AW-1:0] ram_addr;
  logic          ram_we_low;
  logic          ram_we_high;
  logic [15:0]   ram_wdata;
  logic [15:0]   ram_rdata;
  logic          busy;

  int tests_run    = 0;
  int tests_failed = 0;
  int we_low_cnt   = 0;
  int we_high_cnt  = 0;

  logic [15:0] tb_mem  [int];
  logic [15:0] ref_mem [int];

  always #5 clk = ~clk;

  imem_dmem_arbiter #(
    .MEM_LATENCY (L),
    .ADDR_W      (AW),
    .STARVE_LIMIT(3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .imem_r     (imem_r),
    .if_rdata   (if_rdata),
    .d_req      (d_req),
    .d_addr     (d_addr),
    .d_we_low   (d_we_low),
    .d_we_high  (d_we_high),
    .d_wdata    (d_wdata),
    .dmem_r     (dmem_r),
    .d_rdata    (d_rdata),
    .ram_en     (ram_en),
    .ram_addr   (ram_addr),
    .ram_we_low (ram_we_low),
    .ram_we_high(ram_we_high),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .busy       (busy)
  );

  function automatic logic [15:0] pat(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  function automatic logic [15:0] mem_read(input logic [15:0] a);
    if (tb_mem.exists(int'(a))) return tb_mem[int'(a)];
    return pat(a);
  endfunction

  function automatic logic [15:0] ref_read(input logic [15:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return pat(a);
  endfunction

  // Memory component: byte writes on the strobes, read data settled mid-cycle.
  always @(posedge clk) begin
    logic [15:0] w;
    w = mem_read(ram_addr);
    if (ram_we_low)  w[7:0]  = ram_wdata[7:0];
    if (ram_we_high) w[15:8] = ram_wdata[15:8];
    if (ram_we_low || ram_we_high) tb_mem[int'(ram_addr)] = w;
    if (ram_we_low)  we_low_cnt  <= we_low_cnt + 1;
    if (ram_we_high) we_high_cnt <= we_high_cnt + 1;
  end

  always @(negedge clk) ram_rdata <= mem_read(ram_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; if_req = 1'b0; d_req = 1'b0;
    d_we_low = 1'b0; d_we_high = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; if_req = 1'b0; d_req = 1'b0; if_addr = 16'h0000;
    d_addr = 16'h0000; d_we_low = 1'b0; d_we_high = 1'b0; d_wdata = 16'h0000;
    tick(); tick();
    tests_run++;
    if ({imem_r, dmem_r, ram_en, ram_we_low, ram_we_high, busy} !== 6'b000000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {imem_r, dmem_r, ram_en, ram_we_low, ram_we_high, busy});
    end
    tests_run++;
    if ({ram_addr, ram_wdata, if_rdata, d_rdata} !== 64'h0) begin
      tests_failed++;
      $display("FAIL reset_data: got %h want 0", {ram_addr, ram_wdata, if_rdata, d_rdata});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic fetch_op(input logic [15:0] a);
    int n; logic got;
    if_addr = a; if_req = 1'b1;
    tick();
    tests_run++;
    if ({busy, ram_addr} !== {1'b1, a}) begin
      tests_failed++;
      $display("FAIL fetch_grant: got busy=%b addr=%h want 1 %h", busy, ram_addr, a);
    end
    n = 0; got = 1'b0;
    while (!got && n < 40) begin tick(); n++; if (imem_r) got = 1'b1; end
    tests_run++;
    if (!got || n != L) begin
      tests_failed++;
      $display("FAIL fetch_latency: got %0d (seen=%b) want %0d", n, got, L);
    end
    tests_run++;
    if (if_rdata !== ref_read(a)) begin
      tests_failed++;
      $display("FAIL fetch_data @%h: got %h want %h", a, if_rdata, ref_read(a));
    end
    if_req = 1'b0;
    tick();
    tests_run++;
    if (imem_r !== 1'b0) begin
      tests_failed++;
      $display("FAIL fetch_pulse_width: got imem_r=%b want 0", imem_r);
    end
  endtask

  task automatic data_op(input logic [15:0] a, input logic wl, input logic wh,
                         input logic [15:0] wd);
    int n; int l0; int h0; logic got; logic [15:0] e;
    l0 = we_low_cnt; h0 = we_high_cnt;
    d_addr = a; d_we_low = wl; d_we_high = wh; d_wdata = wd; d_req = 1'b1;
    tick();
    tests_run++;
    if ({busy, ram_addr} !== {1'b1, a}) begin
      tests_failed++;
      $display("FAIL data_grant: got busy=%b addr=%h want 1 %h", busy, ram_addr, a);
    end
    n = 0; got = 1'b0;
    while (!got && n < 40) begin tick(); n++; if (dmem_r) got = 1'b1; end
    tests_run++;
    if (!got || n != L) begin
      tests_failed++;
      $display("FAIL data_latency: got %0d (seen=%b) want %0d", n, got, L);
    end
    if (wl || wh) begin
      e = ref_read(a);
      if (wl) e[7:0]  = wd[7:0];
      if (wh) e[15:8] = wd[15:8];
      ref_mem[int'(a)] = e;
      tests_run++;
      if ((we_low_cnt - l0) != int'(wl) || (we_high_cnt - h0) != int'(wh)) begin
        tests_failed++;
        $display("FAIL write_strobes: got lo=%0d hi=%0d want %0d %0d",
                 we_low_cnt - l0, we_high_cnt - h0, wl, wh);
      end
    end else begin
      tests_run++;
      if (d_rdata !== ref_read(a)) begin
        tests_failed++;
        $display("FAIL data_read @%h: got %h want %h", a, d_rdata, ref_read(a));
      end
    end
    d_req = 1'b0; d_we_low = 1'b0; d_we_high = 1'b0;
    tick();
  endtask

  task automatic test_fetch_basic();
    fetch_op(16'h3000);
  endtask

  task automatic test_write_strobe();
    data_op(16'h4000, 1'b1, 1'b0, 16'hABCD);
    data_op(16'h4000, 1'b0, 1'b0, 16'h0000);
    tests_run++;
    if (d_rdata[7:0] !== 8'hCD) begin
      tests_failed++;
      $display("FAIL low_byte_readback: got %h want cd", d_rdata[7:0]);
    end
  endtask

  task automatic test_priority();
    int n; logic got;
    if_addr = 16'h3010; d_addr = 16'h3020; d_we_low = 1'b0; d_we_high = 1'b0;
    if_req = 1'b1; d_req = 1'b1;
    tick();
    tests_run++;
    if ({busy, ram_addr} !== {1'b1, 16'h3020}) begin
      tests_failed++;
      $display("FAIL prio_data_first: got addr=%h want 3020", ram_addr);
    end
    n = 0; got = 1'b0;
    while (!got && n < 40) begin tick(); n++; if (dmem_r) got = 1'b1; end
    tests_run++;
    if (!got || n != L || d_rdata !== ref_read(16'h3020)) begin
      tests_failed++;
      $display("FAIL prio_data_done: got n=%0d data=%h want %0d %h", n, d_rdata, L, ref_read(16'h3020));
    end
    d_req = 1'b0;
    tick();
    tests_run++;
    if ({busy, ram_addr} !== {1'b1, 16'h3010}) begin
      tests_failed++;
      $display("FAIL prio_fetch_in_ready: got busy=%b addr=%h want 1 3010", busy, ram_addr);
    end
    n = 0; got = 1'b0;
    while (!got && n < 40) begin tick(); n++; if (imem_r) got = 1'b1; end
    tests_run++;
    if (!got || n != L || if_rdata !== ref_read(16'h3010)) begin
      tests_failed++;
      $display("FAIL prio_fetch_done: got n=%0d data=%h want %0d %h", n, if_rdata, L, ref_read(16'h3010));
    end
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int n; logic got;
    d_addr = 16'h3100; d_we_low = 1'b0; d_we_high = 1'b0; d_req = 1'b1;
    tick();
    n = 0; got = 1'b0;
    while (!got && n < 40) begin tick(); n++; if (dmem_r) got = 1'b1; end
    d_addr = 16'h3102;
    tick();
    tests_run++;
    if ({busy, ram_addr} !== {1'b1, 16'h3102}) begin
      tests_failed++;
      $display("FAIL b2b_grant: got busy=%b addr=%h want 1 3102", busy, ram_addr);
    end
    n = 0; got = 1'b0;
    while (!got && n < 40) begin tick(); n++; if (dmem_r) got = 1'b1; end
    tests_run++;
    if (!got || n != L || d_rdata !== ref_read(16'h3102)) begin
      tests_failed++;
      $display("FAIL b2b_second: got n=%0d data=%h want %0d %h", n, d_rdata, L, ref_read(16'h3102));
    end
    d_req = 1'b0;
    tick();
  endtask

  task automatic test_if_abort();
    int n; logic got; logic seen_imem;
    if_addr = 16'h3200; if_req = 1'b1;
    tick(); tick(); tick();
    if_req = 1'b0; d_addr = 16'h3204; d_we_low = 1'b0; d_we_high = 1'b0; d_req = 1'b1;
    tick();
    tests_run++;
    if ({busy, imem_r} !== 2'b00) begin
      tests_failed++;
      $display("FAIL abort_idle: got busy=%b imem_r=%b want 0 0", busy, imem_r);
    end
    tick();
    tests_run++;
    if ({busy, ram_addr} !== {1'b1, 16'h3204}) begin
      tests_failed++;
      $display("FAIL abort_d_grant: got busy=%b addr=%h want 1 3204", busy, ram_addr);
    end
    n = 0; got = 1'b0; seen_imem = 1'b0;
    while (!got && n < 40) begin
      tick(); n++;
      if (dmem_r) got = 1'b1;
      if (imem_r) seen_imem = 1'b1;
    end
    tests_run++;
    if (seen_imem || !got || n != L) begin
      tests_failed++;
      $display("FAIL abort_followup: got imem=%b n=%0d want 0 %0d", seen_imem, n, L);
    end
    d_req = 1'b0;
    tick();
  endtask

  task automatic test_write_drop();
    int l0; int h0; logic seen_d; logic [15:0] wd;
    l0 = we_low_cnt; h0 = we_high_cnt; wd = 16'($urandom);
    d_addr = 16'h4200; d_we_low = 1'b1; d_we_high = 1'b1; d_wdata = wd; d_req = 1'b1;
    tick(); tick();
    d_req = 1'b0; d_we_low = 1'b0; d_we_high = 1'b0;
    seen_d = 1'b0;
    for (int i = 0; i < 8; i++) begin tick(); if (dmem_r) seen_d = 1'b1; end
    ref_mem[int'(16'h4200)] = wd;
    tests_run++;
    if (seen_d || (we_low_cnt - l0) != 1 || (we_high_cnt - h0) != 1) begin
      tests_failed++;
      $display("FAIL write_drop: got dmem=%b lo=%0d hi=%0d want 0 1 1",
               seen_d, we_low_cnt - l0, we_high_cnt - h0);
    end
    data_op(16'h4200, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic test_reset_mid_write();
    int l0; int h0;
    l0 = we_low_cnt; h0 = we_high_cnt;
    d_addr = 16'h4100; d_we_low = 1'b1; d_we_high = 1'b1; d_wdata = 16'h1357; d_req = 1'b1;
    tick(); tick();
    reset = 1'b1; d_req = 1'b0; d_we_low = 1'b0; d_we_high = 1'b0;
    tick();
    tests_run++;
    if ({imem_r, dmem_r, ram_en, ram_we_low, ram_we_high, busy, ram_addr, ram_wdata,
         if_rdata, d_rdata} !== 70'h0) begin
      tests_failed++;
      $display("FAIL mid_write_reset: got busy=%b en=%b we=%b%b addr=%h wdata=%h",
               busy, ram_en, ram_we_high, ram_we_low, ram_addr, ram_wdata);
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    tests_run++;
    if ((we_low_cnt - l0) != 0 || (we_high_cnt - h0) != 0) begin
      tests_failed++;
      $display("FAIL mid_write_no_strobe: got lo=%0d hi=%0d want 0 0", we_low_cnt - l0, we_high_cnt - h0);
    end
    data_op(16'h4100, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic test_random();
    logic [15:0] a; int op; logic wl; logic wh;
    for (int i = 0; i < 12; i++) begin
      a  = 16'h5000 | 16'($urandom_range(0, 7));
      op = int'($urandom_range(0, 2));
      if (op == 0) begin
        fetch_op(a);
      end else if (op == 1) begin
        data_op(a, 1'b0, 1'b0, 16'h0000);
      end else begin
        wl = 1'($urandom_range(0, 1));
        wh = wl ? 1'($urandom_range(0, 1)) : 1'b1;
        data_op(a, wl, wh, 16'($urandom));
      end
    end
  endtask

  task automatic test_starve();
    int d_cnt; int i_cnt;
    do_reset();
    if_addr = 16'h3300; d_addr = 16'h3400; d_we_low = 1'b0; d_we_high = 1'b0;
    if_req = 1'b1; d_req = 1'b1;
    d_cnt = 0; i_cnt = 0;
`ifdef IMEM_ARB_STARVE_GUARD_EN
    for (int c = 0; c < 60 && i_cnt == 0; c++) begin
      tick();
      if (dmem_r) d_cnt++;
      if (imem_r) i_cnt++;
    end
    tests_run++;
    if (i_cnt != 1 || d_cnt != 3 || if_rdata !== ref_read(16'h3300)) begin
      tests_failed++;
      $display("FAIL starve_guard: got imem=%0d data_before=%0d want 1 3", i_cnt, d_cnt);
    end
`else
    for (int c = 0; c < 60; c++) begin
      tick();
      if (dmem_r) d_cnt++;
      if (imem_r) i_cnt++;
    end
    tests_run++;
    if (i_cnt != 0 || d_cnt != 12) begin
      tests_failed++;
      $display("FAIL strict_priority: got imem=%0d data=%0d want 0 12", i_cnt, d_cnt);
    end
`endif
    if_req = 1'b0; d_req = 1'b0;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_fetch_basic();
    test_priority();
    test_write_strobe();
    test_back_to_back();
    test_if_abort();
    test_write_drop();
    test_reset_mid_write();
    test_random();
    test_starve();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
